// File: rtl/mux64_scan_ctrl.sv
// ============================================================================
// mux64_scan_ctrl
// Steps a 64:1 mux select through masked channels, settles, samples, and
// assembles the samples into a 64-bit result word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux64_scan_ctrl #(
    parameter int SETTLE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [63:0]         chan_mask_i,
    input  logic [SETTLE_W-1:0] settle_i,
    input  logic                mux_out_i,
    output logic [5:0]          select_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [63:0]         result_o,
    output logic                result_valid_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [5:0]          select_q, select_d;
    logic [63:0]         mask_q, mask_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [63:0]         result_q, result_d;
    logic                rvalid_q, rvalid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                w_start_acc;
    logic [63:0]         w_above;
    logic                w_next_found;
    logic [5:0]          w_next_idx;

    function automatic logic [5:0] lowest_idx(input logic [63:0] v);
        lowest_idx = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = i[5:0];
            end
        end
    endfunction

    assign w_start_acc  = (state_q == S_IDLE) && start_i && !abort_i;
    // 7-bit shift amount so that select 63 leaves no candidates above it.
    assign w_above      = mask_q & ({64{1'b1}} << ({1'b0, select_q} + 7'd1));
    assign w_next_found = |w_above;
    assign w_next_idx   = lowest_idx(w_above);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_acc) begin
                    state_d = (chan_mask_i == 64'd0) ? S_DONE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort_i)              state_d = S_IDLE;
                else if (cnt_q == '0)     state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort_i)              state_d = S_IDLE;
                else if (w_next_found)    state_d = S_SETTLE;
                else                      state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        select_d = select_q;
        mask_d   = mask_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rvalid_d = rvalid_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_acc) begin
                    mask_d   = chan_mask_i;
                    settle_d = settle_i;
                    result_d = 64'd0;
                    rvalid_d = 1'b0;
                    if (chan_mask_i != 64'd0) begin
                        select_d = lowest_idx(chan_mask_i);
                        cnt_d    = settle_i;
                    end
                end
            end
            S_SETTLE: begin
                if (!abort_i && cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SAMPLE: begin
                if (!abort_i) begin
                    result_d[select_q] = mux_out_i;
                    if (w_next_found) begin
                        select_d = w_next_idx;
                        cnt_d    = settle_q;
                    end
                end
            end
            default: ;
        endcase
        if (state_d == S_DONE) begin
            rvalid_d = 1'b1;
        end
        busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select_q <= 6'd0;
            mask_q   <= 64'd0;
            settle_q <= '0;
            cnt_q    <= '0;
            result_q <= 64'd0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            select_q <= select_d;
            mask_q   <= mask_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign select_o       = select_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign result_o       = result_q;
    assign result_valid_o = rvalid_q;

endmodule

`default_nettype wire
